// File: rtl/mux_sel_pkg.sv
// Shared definitions for the mux_sel_arbiter codebase slice.
// Contents: FSM state encodings, mux select encodings, and the beat-counter width helper.
package mux_sel_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_GRANT_A = 2'd1;
  localparam state_t ST_GRANT_B = 2'd2;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Width that can hold 0..burst_len.
  function automatic int unsigned cnt_width(input int unsigned burst_len);
    return $clog2(burst_len + 1);
  endfunction

endpackage

// File: rtl/mux_out_reg.sv
// Single-entry valid/ready output register with full throughput.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   in_valid, in_data    upstream beat offered
//   in_ready             space available (!out_valid | out_ready), combinational
//   out_valid, out_data  registered downstream beat
//   out_ready            downstream accepts
module mux_out_reg #(
  parameter int unsigned DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
);

  assign in_ready = !out_valid || out_ready;

  // Load on accept; clear valid when popped without a replacement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Two-source arbiter feeding the 2:1 mux: grants A or B for up to BURST_LEN
// beats, drives the mux select and steers the granted stream into a registered
// output stage.
// Optional: define MUX_SEL_FIXED_PRIO_EN to make A always win (B may starve);
// default build is round-robin.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   a_valid, a_data, a_ready      source A stream (a_ready combinational on space)
//   b_valid, b_data, b_ready      source B stream (b_ready combinational on space)
//   select                        registered grant, 0=A 1=B, held in IDLE
//   out_valid, out_data, out_ready registered output stream
module mux_sel_arbiter
  import mux_sel_pkg::*;
#(
  parameter int unsigned DATA_W    = 1,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              select,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
);

  localparam int unsigned CNT_W = cnt_width(BURST_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

  state_t           state_q, state_d;
  logic             sel_q, sel_d;
  logic             prio_q, prio_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             space;
  logic             yield;
  logic             grant_valid;
  logic [DATA_W-1:0] grant_data;

  assign a_ready = (state_q == ST_GRANT_A) && space;
  assign b_ready = (state_q == ST_GRANT_B) && space;
  assign select  = sel_q;

  // Offer only the granted source to the output register.
  assign grant_valid = ((state_q == ST_GRANT_A) && a_valid) ||
                       ((state_q == ST_GRANT_B) && b_valid);
  assign grant_data  = (state_q == ST_GRANT_B) ? b_data : a_data;

  mux_out_reg #(.DATA_W(DATA_W)) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (grant_valid),
    .in_data   (grant_data),
    .in_ready  (space),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= SEL_A;
      prio_q  <= SEL_A;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      prio_q  <= prio_d;
      count_q <= count_d;
    end
  end

  // Next-state: grant selection, burst counting and release handoff.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    prio_d  = prio_q;
    count_d = count_q;
    yield   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (a_valid && (!b_valid || (prio_q == SEL_A))) begin
          state_d = ST_GRANT_A;
          sel_d   = SEL_A;
        end else if (b_valid) begin
          state_d = ST_GRANT_B;
          sel_d   = SEL_B;
        end
      end
      ST_GRANT_A: begin
        if (!a_valid) begin
          yield = 1'b1;
        end else if (space) begin
          if (count_q == CNT_LAST) yield = 1'b1;
          else count_d = count_q + CNT_W'(1);
        end
      end
      ST_GRANT_B: begin
        if (!b_valid) begin
          yield = 1'b1;
        end else if (space) begin
          if (count_q == CNT_LAST) yield = 1'b1;
          else count_d = count_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Release: hand straight to the next eligible source, else fall to IDLE.
    if (yield) begin
      count_d = '0;
`ifdef MUX_SEL_FIXED_PRIO_EN
      prio_d = SEL_A;
      if (a_valid) begin
        state_d = ST_GRANT_A;
        sel_d   = SEL_A;
      end else if ((state_q == ST_GRANT_A) && b_valid) begin
        state_d = ST_GRANT_B;
        sel_d   = SEL_B;
      end else begin
        state_d = ST_IDLE;
      end
`else
      prio_d = (state_q == ST_GRANT_A) ? SEL_B : SEL_A;
      if ((state_q == ST_GRANT_A) && b_valid) begin
        state_d = ST_GRANT_B;
        sel_d   = SEL_B;
      end else if ((state_q == ST_GRANT_B) && a_valid) begin
        state_d = ST_GRANT_A;
        sel_d   = SEL_A;
      end else begin
        state_d = ST_IDLE;
      end
`endif
    end
  end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed bench for mux_sel_arbiter (DATA_W=1, BURST_LEN=4).
// Vector encoding per cycle: {a_valid,a_data,b_valid,b_data,out_ready,
//                             a_ready,b_ready,select,out_valid,out_data}.
// Inputs are driven on the falling edge, outputs checked 1ns later.
module tb_mux_sel_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a_valid = 1'b0, a_data = 1'b0, a_ready;
  logic b_valid = 1'b0, b_data = 1'b0, b_ready;
  logic select, out_valid, out_data;
  logic out_ready = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mux_sel_arbiter #(.DATA_W(1), .BURST_LEN(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_valid   (a_valid),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .select    (select),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  task automatic drive(input logic [4:0] in);
    {a_valid, a_data, b_valid, b_data, out_ready} = in;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(5'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(5'($urandom_range(0, 31)));
      #1;
      n_checks++;
      if ({select, out_valid, out_data, a_ready, b_ready} !== 5'b0)
        $display("FAIL reset c%0d sel/ov/od/ar/br got %b exp 00000", i,
                 {select, out_valid, out_data, a_ready, b_ready});
      else n_pass++;
    end
    @(negedge clk);
    drive(5'b0);
    rst_n = 1'b1;
  endtask

  task automatic test_single_source();
    logic [9:0] v [8];
    v = '{10'b11001_00000, 10'b11001_10000, 10'b10001_10011, 10'b11001_10010,
          10'b11001_10011, 10'b10001_00011, 10'b10001_10000, 10'b10001_10010};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(v[i][9:5]);
      #1;
      n_checks++;
      if ({a_ready, b_ready, select, out_valid} !== v[i][4:1])
        $display("FAIL single c%0d ar/br/sel/ov got %b exp %b", i,
                 {a_ready, b_ready, select, out_valid}, v[i][4:1]);
      else n_pass++;
      if (v[i][1]) begin
        n_checks++;
        if (out_data !== v[i][0])
          $display("FAIL single c%0d out_data got %b exp %b", i, out_data, v[i][0]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_contention();
    logic [9:0] v [11];
    v = '{10'b11101_00000, 10'b11101_10000, 10'b11101_10011, 10'b11101_10011,
          10'b11101_10011, 10'b11101_01111, 10'b11101_01110, 10'b11101_01110,
          10'b11101_01110, 10'b11101_10010, 10'b11101_10011};
    do_reset();
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive(v[i][9:5]);
      #1;
      n_checks++;
      if ({a_ready, b_ready, select, out_valid} !== v[i][4:1])
        $display("FAIL contention c%0d ar/br/sel/ov got %b exp %b", i,
                 {a_ready, b_ready, select, out_valid}, v[i][4:1]);
      else n_pass++;
      if (v[i][1]) begin
        n_checks++;
        if (out_data !== v[i][0])
          $display("FAIL contention c%0d out_data got %b exp %b", i, out_data, v[i][0]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [9:0] v [12];
    v = '{10'b00111_00000, 10'b00111_01100, 10'b00101_01111, 10'b00110_00110,
          10'b00110_00110, 10'b00110_00110, 10'b00110_00110, 10'b00110_00110,
          10'b00111_01110, 10'b00101_01111, 10'b00001_00110, 10'b00001_00100};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(v[i][9:5]);
      #1;
      n_checks++;
      if ({a_ready, b_ready, select, out_valid} !== v[i][4:1])
        $display("FAIL backpressure c%0d ar/br/sel/ov got %b exp %b", i,
                 {a_ready, b_ready, select, out_valid}, v[i][4:1]);
      else n_pass++;
      if (v[i][1]) begin
        n_checks++;
        if (out_data !== v[i][0])
          $display("FAIL backpressure c%0d out_data got %b exp %b", i, out_data, v[i][0]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_early_drop();
    logic [9:0] v [6];
    v = '{10'b11111_00000, 10'b11111_10000, 10'b10111_10011, 10'b00111_10010,
          10'b00111_01100, 10'b00111_01111};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(v[i][9:5]);
      #1;
      n_checks++;
      if ({a_ready, b_ready, select, out_valid} !== v[i][4:1])
        $display("FAIL early_drop c%0d ar/br/sel/ov got %b exp %b", i,
                 {a_ready, b_ready, select, out_valid}, v[i][4:1]);
      else n_pass++;
      if (v[i][1]) begin
        n_checks++;
        if (out_data !== v[i][0])
          $display("FAIL early_drop c%0d out_data got %b exp %b", i, out_data, v[i][0]);
        else n_pass++;
      end
    end
  endtask

  // Reset while B holds the grant: beat dropped, prio back to A.
  task automatic test_mid_reset();
    do_reset();
    drive(5'b11101);
    repeat (6) @(negedge clk);
    #1;
    n_checks++;
    if ({b_ready, select} !== 2'b11)
      $display("FAIL mid_reset pre br/sel got %b exp 11", {b_ready, select});
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({a_ready, b_ready, select, out_valid, out_data} !== 5'b0)
      $display("FAIL mid_reset async ar/br/sel/ov/od got %b exp 00000",
               {a_ready, b_ready, select, out_valid, out_data});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if ({a_ready, b_ready, select} !== 3'b000)
      $display("FAIL mid_reset idle ar/br/sel got %b exp 000", {a_ready, b_ready, select});
    else n_pass++;
    @(negedge clk);
    #1;
    n_checks++;
    if ({a_ready, b_ready, select} !== 3'b100)
      $display("FAIL mid_reset regrant ar/br/sel got %b exp 100", {a_ready, b_ready, select});
    else n_pass++;
  endtask

`ifdef MUX_SEL_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    do_reset();
    drive(5'b11101);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if ({b_ready, select} !== 2'b00)
        $display("FAIL fixed_prio c%0d br/sel got %b exp 00", i, {b_ready, select});
      else n_pass++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_source();
    test_contention();
    test_backpressure();
    test_early_drop();
    test_mid_reset();
`ifdef MUX_SEL_FIXED_PRIO_EN
    test_fixed_prio();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mux_sel_arbiter.md
Name: mux_sel_arbiter

Overview:
- Two-source round-robin arbiter that sits directly upstream of the 2:1 `mux`.
- Generates the mux `select` and steers one of two valid/ready streams (A, B) into a single registered output stream.
- Holds a grant for up to BURST_LEN beats so short bursts stay contiguous, then yields to the other source.

Parameters:
- DATA_W, 1, width of a_data/b_data/out_data (1 matches the current `mux` datapath).
- BURST_LEN, 4, maximum beats accepted per grant before forced release; legal range 1..255.

Ports:
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- a_valid  input  1  source A beat present
- a_data  input  DATA_W  source A payload
- a_ready  output  1  source A beat accepted this cycle when a_valid&a_ready
- b_valid  input  1  source B beat present
- b_data  input  DATA_W  source B payload
- b_ready  output  1  source B beat accepted this cycle when b_valid&b_ready
- select  output  1  current grant, 0=A, 1=B; drives mux select
- out_valid  output  1  registered output beat present
- out_data  output  DATA_W  registered output payload
- out_ready  input  1  sink accepts when out_valid&out_ready

Behaviour:
- Reset: async assert on rst_n low, sync release. state=IDLE, select=0, out_valid=0, out_data=0, a_ready=b_ready=0, beat count=0, round-robin pointer prio=A.
- States: IDLE, GRANT_A, GRANT_B.
- IDLE:
  - Only a_valid -> GRANT_A.
  - Only b_valid -> GRANT_B.
  - Both valid -> grant the source equal to prio.
  - Neither valid -> stay in IDLE.
  - Nothing is accepted in IDLE. Grant registers, so the first accept is one cycle after the request is seen.
- Space condition: space = !out_valid | out_ready (single-entry output register, full throughput).
- GRANT_x:
  - x_ready = space; the other source's ready = 0.
  - On accept: out_data <= x_data, out_valid <= 1, count++.
  - Latency from accept to out_valid is exactly 1 cycle.
  - If out_ready pops the register with no new accept, out_valid <= 0.
- Release from GRANT_x happens when either:
  - an accept occurs with count == BURST_LEN-1, or
  - x_valid == 0 in the grant cycle (no accept).
- On release:
  - count <= 0 and prio <= other source.
  - If the other source is valid, go directly to GRANT_other with no IDLE bubble. Otherwise go to IDLE.
- select: equals the grant in GRANT_A/GRANT_B and holds its last value in IDLE.
- Backpressure: with out_ready=0 and out_valid=1, no accepts occur. Count and grant hold. Stall cycles never count toward BURST_LEN.
- Simultaneous pop and accept in one cycle: out_data is replaced, out_valid stays 1.
- BURST_LEN=1: release after every accepted beat, so strict alternation when both sources are valid.
- Reset mid-burst: the in-flight output beat is dropped and the state returns to IDLE with prio=A.
- Count width: clog2(BURST_LEN+1). No wrap is possible because the release condition occurs first.

Optional Feature:
- MUX_SEL_FIXED_PRIO_EN:
  - Defined: prio is tied to A. When both sources are valid in IDLE, or at release, A always wins. The burst limit still forces a release, but A regains the grant immediately if a_valid remains high, so B can starve.
  - Undefined: round-robin as described above.

Decomposition:
- Package mux_sel_pkg:
  - state enum (IDLE, GRANT_A, GRANT_B)
  - constants SEL_A=1'b0, SEL_B=1'b1
  - function for the count width
- Sub-module mux_out_reg: the single-entry valid/ready output register (in_valid, in_data, in_ready=space, out_*). The arbiter FSM instantiates it once.

Test Plan:
- Reset: rst_n=0 for 3 cycles with random inputs -> select=0, out_valid=0, out_data=0, a_ready=b_ready=0 throughout.
- Single source: a_valid=1 continuously with data 1,0,1,1,0, out_ready=1 -> sequence:
  - IDLE, then GRANT_A, with out beats 1,0,1,1 on consecutive cycles (1-cycle latency);
  - forced release after 4 beats;
  - one IDLE cycle, then GRANT_A again;
  - select=0 for the whole run.
- Contention: a_valid=b_valid=1 continuously, BURST_LEN=4, out_ready=1 -> select pattern is 0 for 4 beats, then 1 for 4 beats, alternating, with no bubble between grants.
- Backpressure: during GRANT_B, hold out_ready=0 for 5 cycles -> b_ready=0, out_data is stable, count is frozen. Release out_ready -> the burst completes with exactly BURST_LEN total beats.
- Early drop: GRANT_A, a_valid goes low after 2 beats while b_valid=1 -> next cycle GRANT_B, select=1, prio=B.
- MUX_SEL_FIXED_PRIO_EN defined, both sources valid -> select stays 0 and b_ready is never asserted.
